// File: rtl/split_stream_checker_pkg.sv
// Shared types, error-bit positions and the per-variable width table for the
// split stream checker.
package split_pkg;

  localparam int NUM_VARS_DEF = 150;
  localparam int MAX_W_DEF    = 16;

  typedef enum logic [1:0] {
    LEGACY = 2'd0,
    CHECK  = 2'd1,
    STRICT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bit positions inside err_code.
  localparam int ERR_WIDTH = 0;  // missing variable or value wider than declared
  localparam int ERR_RANGE = 1;  // beat index >= NUM_VARS
  localparam int ERR_DUP   = 2;  // variable assigned more than once

  // Declared width of each variable in the split (repeats with period 7).
  localparam int VAR_W [NUM_VARS_DEF] = '{
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16, 4, 12, 16, 6,
    10, 8, 16, 4, 12, 16, 6, 10, 8, 16
  };

  // Satisfied flag as a function of the operating mode and final error bits.
  function automatic logic x_of(mode_e mode, logic [2:0] err);
    logic res;
    res = 1'b1;
    case (mode)
      LEGACY:  res = 1'b1;
      CHECK:   res = ~err[ERR_WIDTH];
      STRICT:  res = (err == 3'b000);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/split_stream_checker_if.sv
// Valid/ready assignment stream: one (index, value) beat per transfer, with a
// last marker on the final beat.
interface split_stream_checker_if #(
  parameter int IDX_W = 8,
  parameter int MAX_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [MAX_W-1:0] in_val;
  logic             in_last;

  modport master (
    output in_valid, in_idx, in_val, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_idx, in_val, in_last,
    output in_ready
  );
endinterface

// File: rtl/split_var_store.sv
// Per-variable value register file with a loaded bitmap; one write port, one
// read port for the scan pointer, and a synchronous bitmap clear.
module split_var_store #(
  parameter int NUM_VARS = 150,
  parameter int MAX_W    = 16,
  parameter int IDX_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [MAX_W-1:0] wr_val,
  output logic             wr_loaded,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [MAX_W-1:0] rd_val,
  output logic             rd_loaded
);

  logic [MAX_W-1:0]    mem [NUM_VARS];
  logic [NUM_VARS-1:0] loaded;

  // NOTE: the value array is deliberately not reset; the loaded bitmap is the
  // only thing that says whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      loaded <= '0;
    end else if (we) begin
      loaded[wr_idx] <= 1'b1;
    end
  end

  // Callers only write in-range indices, so wr_loaded is only consumed then.
  assign wr_loaded = loaded[wr_idx];
  assign rd_val    = mem[rd_idx];
  assign rd_loaded = loaded[rd_idx];

endmodule

// File: rtl/split_stream_checker.sv
// Collects streamed variable assignments, then scans every variable for
// presence and declared-width conformance and reports a satisfied flag.
module split_stream_checker
  import split_pkg::*;
#(
  parameter int    NUM_VARS = NUM_VARS_DEF,
  parameter int    MAX_W    = MAX_W_DEF,
  parameter int    IDX_W    = $clog2(NUM_VARS),
  parameter mode_e MODE     = CHECK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  split_stream_checker_if.slave  in_if,
  output logic                   done,
  output logic                   x,
  output logic [2:0]             err_code
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [2:0]       err_q, err_d;
  logic             x_q, x_d;
  logic             done_q, done_d;

  logic             clr;
  logic             we;
  logic             in_range;
  logic             wr_loaded;
  logic [MAX_W-1:0] rd_val;
  logic             rd_loaded;
  logic             scan_err;

  split_var_store #(
    .NUM_VARS (NUM_VARS),
    .MAX_W    (MAX_W),
    .IDX_W    (IDX_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .we        (we),
    .wr_idx    (in_if.in_idx),
    .wr_val    (in_if.in_val),
    .wr_loaded (wr_loaded),
    .rd_idx    (ptr_q),
    .rd_val    (rd_val),
    .rd_loaded (rd_loaded)
  );

  assign in_range = (in_if.in_idx <= LAST_IDX);
  assign scan_err = !rd_loaded || ((rd_val >> VAR_W[ptr_q]) != '0);

  // Ready is a pure decode of the state register; it never looks at valid.
  assign in_if.in_ready = (state_q == LOAD);

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    x_d     = x_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    we      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = '0;
          err_d   = '0;
          x_d     = 1'b0;
          clr     = 1'b1;
        end
      end

      LOAD: begin
        if (in_if.in_valid) begin
          we = in_range;
          if (in_range && wr_loaded) err_d[ERR_DUP]   = 1'b1;
          if (!in_range)             err_d[ERR_RANGE] = 1'b1;
          if (in_if.in_last) begin
            state_d = SCAN;
            ptr_d   = '0;
          end
        end
      end

      SCAN: begin
        if (scan_err) err_d[ERR_WIDTH] = 1'b1;
        // The last variable's verdict must already be folded into x.
        if (ptr_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          x_d     = x_of(MODE, err_d);
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      err_q   <= '0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      x_q     <= x_d;
      done_q  <= done_d;
    end
  end

  assign done     = done_q;
  assign x        = x_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_split_stream_checker.sv
// Directed bench: three checkers (LEGACY/CHECK/STRICT) share one stimulus
// stream; each scenario task compares outputs against hand-derived values.
module tb_split_stream_checker;
  import split_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, valid, last;
  logic [7:0]  idx;
  logic [15:0] val;
  logic        done_l, done_c, done_s;
  logic        x_l, x_c, x_s;
  logic [2:0]  err_l, err_c, err_s;

  int total = 0;
  int bad   = 0;

  int          bi [$];
  logic [15:0] bv [$];

  always #5 clk = ~clk;

  split_stream_checker_if #(.IDX_W(8), .MAX_W(16)) if_l ();
  split_stream_checker_if #(.IDX_W(8), .MAX_W(16)) if_c ();
  split_stream_checker_if #(.IDX_W(8), .MAX_W(16)) if_s ();

  assign if_l.in_valid = valid;  assign if_l.in_idx = idx;
  assign if_l.in_val   = val;    assign if_l.in_last = last;
  assign if_c.in_valid = valid;  assign if_c.in_idx = idx;
  assign if_c.in_val   = val;    assign if_c.in_last = last;
  assign if_s.in_valid = valid;  assign if_s.in_idx = idx;
  assign if_s.in_val   = val;    assign if_s.in_last = last;

  split_stream_checker #(.MODE(LEGACY)) u_legacy (
    .clk(clk), .rst(rst), .start(start), .in_if(if_l),
    .done(done_l), .x(x_l), .err_code(err_l));
  split_stream_checker #(.MODE(CHECK)) u_check (
    .clk(clk), .rst(rst), .start(start), .in_if(if_c),
    .done(done_c), .x(x_c), .err_code(err_c));
  split_stream_checker #(.MODE(STRICT)) u_strict (
    .clk(clk), .rst(rst), .start(start), .in_if(if_s),
    .done(done_s), .x(x_s), .err_code(err_s));

  // Declared widths: var0=10, var5=16, var17=4, var149=16 (period-7 pattern).
  function automatic int tb_w(int i);
    case (i % 7)
      0: return 10;
      1: return 8;
      2: return 16;
      3: return 4;
      4: return 12;
      5: return 16;
      default: return 6;
    endcase
  endfunction

  function automatic logic [15:0] full_val(int i);
    int v;
    v = (1 << tb_w(i)) - 1;
    return v[15:0];
  endfunction

  task automatic build_full();
    bi.delete();
    bv.delete();
    for (int i = 0; i < 150; i++) begin
      bi.push_back(i);
      bv.push_back(full_val(i));
    end
  endtask

  // Pulses start, streams bi/bv, then counts cycles until done. n is the
  // cycle number relative to the cycle that carried the last beat (-1 = timeout).
  task automatic run_stream(input bit stall, input int start_at, input int rst_at,
                            output int n, output logic [2:0] err_pre_rst,
                            output logic rdy_start, output logic rdy_last);
    int guard;
    bit acc;
    err_pre_rst = 3'b000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rdy_start = if_c.in_ready;
    for (int k = 0; k < bi.size(); k++) begin
      idx   = 8'(bi[k]);
      val   = bv[k];
      last  = (k == bi.size() - 1);
      guard = 0;
      forever begin
        valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        acc   = valid && if_c.in_ready;
        @(posedge clk);
        @(negedge clk);
        if (acc) break;
        guard++;
        if (guard > 1000) begin
          total++; bad++;
          $display("FAIL beat_accept: beat %0d not accepted within 1000 cycles", k);
          valid = 1'b0; last = 1'b0; n = -1; rdy_last = 1'bx;
          return;
        end
      end
    end
    valid    = 1'b0;
    last     = 1'b0;
    rdy_last = if_c.in_ready;
    n = 1;
    while (!done_c && n < 400) begin
      if (n == start_at) start = 1'b1;
      if (n == rst_at) begin
        err_pre_rst = err_c;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (!done_c) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; idx = '0; val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (if_c.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", if_c.in_ready); end
    total++; if (done_c !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_c); end
    total++; if (x_c !== 1'b0) begin bad++; $display("FAIL reset_x: got %b want 0", x_c); end
    total++; if (err_c !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", err_c); end
    total++; if (x_l !== 1'b0) begin bad++; $display("FAIL reset_x_legacy: got %b want 0", x_l); end
  endtask

  task automatic test_full_load();
    int n; logic [2:0] ep; logic rs, rl;
    build_full();
    run_stream(1'b0, -1, -1, n, ep, rs, rl);
    total++; if (rs !== 1'b1) begin bad++; $display("FAIL full_ready_after_start: got %b want 1", rs); end
    total++; if (rl !== 1'b0) begin bad++; $display("FAIL full_ready_after_last: got %b want 0", rl); end
    total++; if (n != 151) begin bad++; $display("FAIL full_latency: got %0d want 151", n); end
    total++; if (x_c !== 1'b1) begin bad++; $display("FAIL full_x_check: got %b want 1", x_c); end
    total++; if (err_c !== 3'b000) begin bad++; $display("FAIL full_err_check: got %b want 000", err_c); end
    total++; if (x_s !== 1'b1) begin bad++; $display("FAIL full_x_strict: got %b want 1", x_s); end
    @(posedge clk);
    @(negedge clk);
    total++; if (done_c !== 1'b0) begin bad++; $display("FAIL full_done_pulse: got %b want 0", done_c); end
    total++; if (x_c !== 1'b1) begin bad++; $display("FAIL full_x_held: got %b want 1", x_c); end
  endtask

  task automatic test_width();
    int n; logic [2:0] ep; logic rs, rl;
    build_full();
    bv[17] = 16'h0010;
    run_stream(1'b0, -1, -1, n, ep, rs, rl);
    total++; if (n != 151) begin bad++; $display("FAIL width_latency: got %0d want 151", n); end
    total++; if (x_c !== 1'b0) begin bad++; $display("FAIL width_x_check: got %b want 0", x_c); end
    total++; if (err_c !== 3'b001) begin bad++; $display("FAIL width_err_check: got %b want 001", err_c); end
    total++; if (x_l !== 1'b1) begin bad++; $display("FAIL width_x_legacy: got %b want 1", x_l); end
  endtask

  task automatic test_missing();
    int n; logic [2:0] ep; logic rs, rl;
    build_full();
    bi.delete(42);
    bv.delete(42);
    run_stream(1'b0, -1, -1, n, ep, rs, rl);
    total++; if (x_c !== 1'b0) begin bad++; $display("FAIL missing_x_check: got %b want 0", x_c); end
    total++; if (err_c !== 3'b001) begin bad++; $display("FAIL missing_err_check: got %b want 001", err_c); end
  endtask

  task automatic test_duplicate();
    int n; logic [2:0] ep; logic rs, rl;
    build_full();
    bi.insert(8, 7);
    bv.insert(8, 16'h0005);
    run_stream(1'b0, -1, -1, n, ep, rs, rl);
    total++; if (x_s !== 1'b0) begin bad++; $display("FAIL dup_x_strict: got %b want 0", x_s); end
    total++; if (err_s !== 3'b100) begin bad++; $display("FAIL dup_err_strict: got %b want 100", err_s); end
    total++; if (x_c !== 1'b1) begin bad++; $display("FAIL dup_x_check: got %b want 1", x_c); end
  endtask

  // Runs right after test_duplicate: CHECK sits in DONE with x=1, err=100.
  task automatic test_back_to_back();
    int n; logic [2:0] ep; logic rs, rl;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (err_c !== 3'b100) begin bad++; $display("FAIL b2b_err_stable: got %b want 100", err_c); end
    total++; if (x_c !== 1'b1) begin bad++; $display("FAIL b2b_x_stable: got %b want 1", x_c); end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++; if (err_c !== 3'b000) begin bad++; $display("FAIL b2b_err_clear: got %b want 000", err_c); end
    total++; if (x_c !== 1'b0) begin bad++; $display("FAIL b2b_x_clear: got %b want 0", x_c); end
    total++; if (if_c.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", if_c.in_ready); end
    // run_stream pulses start again while already in LOAD; that must be ignored.
    build_full();
    run_stream(1'b0, -1, -1, n, ep, rs, rl);
    total++; if (n != 151) begin bad++; $display("FAIL b2b_latency: got %0d want 151", n); end
    total++; if (err_s !== 3'b000) begin bad++; $display("FAIL b2b_err_final: got %b want 000", err_s); end
  endtask

  task automatic test_range();
    int n; logic [2:0] ep; logic rs, rl;
    bi.delete(); bv.delete();
    bi.push_back(200);
    bv.push_back(16'h0001);
    run_stream(1'b0, -1, -1, n, ep, rs, rl);
    total++; if (rl !== 1'b0) begin bad++; $display("FAIL range_load_end: ready got %b want 0", rl); end
    total++; if (n != 151) begin bad++; $display("FAIL range_latency: got %0d want 151", n); end
    total++; if (err_s !== 3'b011) begin bad++; $display("FAIL range_err_strict: got %b want 011", err_s); end
    total++; if (x_s !== 1'b0) begin bad++; $display("FAIL range_x_strict: got %b want 0", x_s); end
  endtask

  task automatic test_legacy_empty();
    int n; logic [2:0] ep; logic rs, rl;
    bi.delete(); bv.delete();
    bi.push_back(0);
    bv.push_back(16'h0000);
    run_stream(1'b0, -1, -1, n, ep, rs, rl);
    total++; if (x_l !== 1'b1) begin bad++; $display("FAIL legacy_x: got %b want 1", x_l); end
    total++; if (err_l !== 3'b001) begin bad++; $display("FAIL legacy_err: got %b want 001", err_l); end
    total++; if (x_c !== 1'b0) begin bad++; $display("FAIL legacy_x_check: got %b want 0", x_c); end
  endtask

  task automatic test_stall();
    int n; logic [2:0] ep; logic rs, rl;
    build_full();
    run_stream(1'b1, -1, -1, n, ep, rs, rl);
    total++; if (n != 151) begin bad++; $display("FAIL stall_latency: got %0d want 151", n); end
    total++; if (x_s !== 1'b1) begin bad++; $display("FAIL stall_x_strict: got %b want 1", x_s); end
    total++; if (err_s !== 3'b000) begin bad++; $display("FAIL stall_err: got %b want 000", err_s); end
  endtask

  task automatic test_start_in_scan();
    int n; logic [2:0] ep; logic rs, rl;
    build_full();
    bv[5] = 16'h0000;
    run_stream(1'b0, 10, -1, n, ep, rs, rl);
    total++; if (n != 151) begin bad++; $display("FAIL scan_start_latency: got %0d want 151", n); end
    total++; if (x_c !== 1'b1) begin bad++; $display("FAIL scan_start_x: got %b want 1", x_c); end
  endtask

  task automatic test_reset_mid_scan();
    int n; int pulses; logic [2:0] ep; logic rs, rl;
    build_full();
    bi.insert(8, 7);
    bv.insert(8, 16'h0005);
    run_stream(1'b0, -1, 76, n, ep, rs, rl);
    total++; if (ep !== 3'b100) begin bad++; $display("FAIL rst_err_before: got %b want 100", ep); end
    total++; if (err_c !== 3'b000) begin bad++; $display("FAIL rst_err_after: got %b want 000", err_c); end
    total++; if (x_c !== 1'b0) begin bad++; $display("FAIL rst_x_after: got %b want 0", x_c); end
    total++; if (if_c.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_after: got %b want 0", if_c.in_ready); end
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_c) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rst_no_done: got %0d pulses want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_width();
    test_missing();
    test_duplicate();
    test_back_to_back();
    test_range();
    test_legacy_empty();
    test_stall();
    test_start_in_scan();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
